// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: architectural PC owner and instruction-fetch sequencer.
//
// Fetches the word at pc through a req/ready handshake and holds it for decode.
// Loads the next PC when decode accepts the word. Freezes when the HLT opcode is fetched.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   next_pc        next PC from the PC-update logic
//   pc_update      decode accepts instr; load next_pc (HOLD only)
//   stall          blocks the PC load while high
//   imem_addr      fetch address (equals pc)
//   imem_req       read request, high while in REQ
//   imem_rdata     instruction word from memory
//   imem_ready     memory returns data this cycle
//   pc             current PC
//   instr          captured instruction
//   instr_valid    instr valid for decode
//   halted         HLT fetched, sequencer frozen
//   misalign       sticky: an odd next_pc was loaded (PC force-aligned)
//   fetch_cnt      instructions captured since reset, wraps
//   timeout_err    sticky memory-timeout flag
//
// Optional feature: define FETCH_TIMEOUT_EN to enable the REQ timeout/retry logic.
// Without it REQ waits indefinitely and timeout_err is tied to 0.

module pc_fetch_seq #(
  parameter logic [15:0] RESET_VECTOR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE    = 4'hF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_pc,
  input  logic        pc_update,
  input  logic        stall,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign,
  output logic [15:0] fetch_cnt,
  output logic        timeout_err
);

  // StGap is the one-cycle request drop after a timeout; unreachable without FETCH_TIMEOUT_EN.
  typedef enum logic [1:0] {StReq, StHold, StHalt, StGap} state_e;

  state_e state;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tout_cnt;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  assign imem_req  = (state == StReq);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StReq;
      pc          <= RESET_VECTOR;
      instr       <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      misalign    <= 1'b0;
      fetch_cnt   <= 16'h0000;
`ifdef FETCH_TIMEOUT_EN
      tout_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        StReq: begin
          // Ready wins over a timeout landing on the same cycle.
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            fetch_cnt   <= fetch_cnt + 16'd1;
            if (imem_rdata[15:12] == HALT_OPCODE) begin
              state  <= StHalt;
              halted <= 1'b1;
            end else begin
              state <= StHold;
            end
`ifdef FETCH_TIMEOUT_EN
            tout_cnt <= '0;
          end else if (tout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th cycle without ready: drop req, then retry same pc.
            timeout_err <= 1'b1;
            tout_cnt    <= '0;
            state       <= StGap;
          end else begin
            tout_cnt <= tout_cnt + TW'(1);
`endif
          end
        end
        StHold: begin
          // stall overrides pc_update; odd targets are aligned and flagged.
          if (pc_update && !stall) begin
            pc          <= {next_pc[15:1], 1'b0};
            instr_valid <= 1'b0;
            state       <= StReq;
            if (next_pc[0]) misalign <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            tout_cnt <= '0;
`endif
          end
        end
        StHalt: begin
          // Frozen until reset.
        end
        StGap: begin
          state <= StReq;
        end
        default: begin
          state <= StReq;
        end
      endcase
    end
  end

endmodule
